// File: rtl/out_port_bank.sv
// -----------------------------------------------------------------------------
// out_port_bank
//   Bank of NUM_PORTS registered output ports, each WIDTH bits wide. Writers
//   post {sel, op, data} requests into a DEPTH-entry queue. One entry is drained
//   per cycle and applied to the selected port's shadow register as one of:
//   load, set bits, clear bits or toggle bits.
//   With ATOMIC=0, the ports follow the shadows directly.
//   With ATOMIC=1, every port is refreshed from its shadow together when the
//   latch input is high.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   wr_en     in   write request this cycle
//   wr_sel    in   target port index (SEL_W bits)
//   wr_op     in   00 load, 01 set, 10 clear, 11 toggle
//   wr_data   in   operand: a value for load, a bit mask for the other ops
//   wr_ready  out  queue not full (registered)
//   hold      in   stall draining of the queue
//   latch     in   commit all shadows to port_out (ATOMIC=1 only)
//   clr_err   in   clear ovf_err
//   port_out  out  registered ports; port k is at [k*WIDTH +: WIDTH]
//   count     out  queue occupancy
//   ovf_err   out  sticky flag: a write was dropped because the queue was full
// -----------------------------------------------------------------------------
module out_port_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      NUM_PORTS = 4,
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      ATOMIC    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int unsigned     SEL_W     = $clog2(NUM_PORTS),
  localparam int unsigned     CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [1:0]                 wr_op,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  input  logic                       hold,
  input  logic                       latch,
  input  logic                       clr_err,
  output logic [NUM_PORTS*WIDTH-1:0] port_out,
  output logic [CNT_W-1:0]           count,
  output logic                       ovf_err
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      ENT_W   = SEL_W + 2 + WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  // Read-modify-write of one port value.
  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] cur,
                                                input logic [1:0]       op,
                                                input logic [WIDTH-1:0] opnd);
    logic [WIDTH-1:0] res;
    case (op)
      OP_LOAD: res = opnd;
      OP_SET:  res = cur | opnd;
      OP_CLR:  res = cur & ~opnd;
      OP_TGL:  res = cur ^ opnd;
      default: res = cur;
    endcase
    return res;
  endfunction

  logic [ENT_W-1:0] fifo_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             wr_ready_r;
  logic             ovf_err_r;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic [ENT_W-1:0] head_s;
  logic [SEL_W-1:0] head_sel_s;
  logic [1:0]       head_op_s;
  logic [WIDTH-1:0] head_data_s;
  logic [WIDTH-1:0] shadow_r     [NUM_PORTS];
  logic [WIDTH-1:0] shadow_nxt_s [NUM_PORTS];
  logic [WIDTH-1:0] out_r        [NUM_PORTS];

  // wr_ready_r is registered, so accept/drop never depends combinationally on
  // wr_en. The pop decision uses the current count only, so an entry pushed
  // into an empty queue is first applied on the following edge.
  assign push_s = wr_en & wr_ready_r;
  assign drop_s = wr_en & ~wr_ready_r;
  assign pop_s  = (count_r != {CNT_W{1'b0}}) & ~hold;

  assign head_s      = fifo_r[rd_ptr_r];
  assign head_sel_s  = head_s[ENT_W-1 -: SEL_W];
  assign head_op_s   = head_s[WIDTH+1 : WIDTH];
  assign head_data_s = head_s[WIDTH-1:0];

  // Next occupancy. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Queue storage. No reset is needed because the valid range is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= {wr_sel, wr_op, wr_data};
    end
  end

  // Queue pointers, occupancy, ready flag and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      wr_ready_r <= 1'b1;
      ovf_err_r  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_nxt_s;
      wr_ready_r <= (count_nxt_s < DEPTH_C);
      // If a write is dropped in the same cycle that clr_err is high, the flag stays set.
      if (drop_s) begin
        ovf_err_r <= 1'b1;
      end else if (clr_err) begin
        ovf_err_r <= 1'b0;
      end
    end
  end

  // Apply the popped entry to its shadow. An out-of-range sel matches no port,
  // so such an entry is consumed without changing anything.
  always_comb begin
    shadow_nxt_s = shadow_r;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (pop_s && (head_sel_s == SEL_W'(k))) begin
        shadow_nxt_s[k] = apply_op(shadow_r[k], head_op_s, head_data_s);
      end else begin
        shadow_nxt_s[k] = shadow_r[k];
      end
    end
  end

  // Shadow and output registers. In atomic mode, latch captures the pre-pop
  // shadow, so an update popped on the same edge appears at the next latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        shadow_r[k] <= RESET_VAL;
        out_r[k]    <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        shadow_r[k] <= shadow_nxt_s[k];
        if (ATOMIC == 0) begin
          out_r[k] <= shadow_nxt_s[k];
        end else if (latch) begin
          out_r[k] <= shadow_r[k];
        end else begin
          out_r[k] <= out_r[k];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign port_out[g*WIDTH +: WIDTH] = out_r[g];
  end

  assign wr_ready = wr_ready_r;
  assign count    = count_r;
  assign ovf_err  = ovf_err_r;

endmodule

// File: tb/tb_out_port_bank.sv
// -----------------------------------------------------------------------------
// tb_out_port_bank
//   Directed bench for out_port_bank. All three instances share the same
//   stimulus:
//     u_dir  ATOMIC=0, NUM_PORTS=4
//     u_atm  ATOMIC=1, NUM_PORTS=4
//     u_sel  ATOMIC=0, NUM_PORTS=5
//   u_sel has a 3-bit wr_sel, so sel=5 is a real out-of-range index for it.
//   The 4-port instances see only wr_sel[1:0].
// -----------------------------------------------------------------------------
module tb_out_port_bank;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_sel = 3'd0;
  logic [1:0]  wr_op = 2'b00;
  logic [7:0]  wr_data = 8'h00;
  logic        hold = 1'b0;
  logic        latch = 1'b0;
  logic        clr_err = 1'b0;

  logic        rdy_d, rdy_a, rdy_s;
  logic [31:0] po_d, po_a;
  logic [39:0] po_s;
  logic [2:0]  cnt_d, cnt_a, cnt_s;
  logic        ovf_d, ovf_a, ovf_s;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  out_port_bank #(.WIDTH(8), .NUM_PORTS(4), .DEPTH(4), .ATOMIC(0)) u_dir (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel[1:0]), .wr_op(wr_op),
    .wr_data(wr_data), .wr_ready(rdy_d), .hold(hold), .latch(latch),
    .clr_err(clr_err), .port_out(po_d), .count(cnt_d), .ovf_err(ovf_d));

  out_port_bank #(.WIDTH(8), .NUM_PORTS(4), .DEPTH(4), .ATOMIC(1)) u_atm (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel[1:0]), .wr_op(wr_op),
    .wr_data(wr_data), .wr_ready(rdy_a), .hold(hold), .latch(latch),
    .clr_err(clr_err), .port_out(po_a), .count(cnt_a), .ovf_err(ovf_a));

  out_port_bank #(.WIDTH(8), .NUM_PORTS(5), .DEPTH(4), .ATOMIC(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_op(wr_op),
    .wr_data(wr_data), .wr_ready(rdy_s), .hold(hold), .latch(latch),
    .clr_err(clr_err), .port_out(po_s), .count(cnt_s), .ovf_err(ovf_s));

  // Count one comparison and report it if it differs.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one write request. The caller clears wr_en when it is done.
  task automatic drive(input logic [2:0] sel, input logic [1:0] op, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_op   = op;
    wr_data = data;
  endtask

  logic [1:0]  seq_op   [4] = '{OP_LD, OP_SET, OP_CLR, OP_TGL};
  logic [7:0]  seq_data [4] = '{8'hF0, 8'h0F, 8'h30, 8'hFF};
  logic [7:0]  seq_exp  [4] = '{8'hF0, 8'hFF, 8'hCF, 8'h30};
  logic [7:0]  hold_dat [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [31:0] drain_exp[4] = '{32'h77A5_3001, 32'h77A5_0201, 32'h7703_0201, 32'h0403_0201};

  initial begin
    // Reset takes effect with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_port", {32'h0, po_d}, 64'h0);
    chk("rst_count", {61'h0, cnt_d}, 64'h0);
    chk("rst_ready", {63'h0, rdy_d}, 64'h1);
    chk("rst_ovf", {63'h0, ovf_d}, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Load port 2 with 0xA5. port_out changes one edge after the push edge.
    drive(3'd2, OP_LD, 8'hA5);
    tick();
    wr_en = 1'b0;
    chk("load_count", {61'h0, cnt_d}, 64'h1);
    chk("load_early", {32'h0, po_d}, 64'h0);
    tick();
    chk("load_port", {32'h0, po_d}, 64'h00A5_0000);
    chk("load_atm_hold", {32'h0, po_a}, 64'h0);

    // Back-to-back operations on port 1.
    for (int i = 0; i < 4; i++) begin
      drive(3'd1, seq_op[i], seq_data[i]);
      tick();
      if (i > 0) chk("seq_p1", {56'h0, po_d[15:8]}, {56'h0, seq_exp[i-1]});
    end
    wr_en = 1'b0;
    tick();
    chk("seq_p1", {56'h0, po_d[15:8]}, {56'h0, seq_exp[3]});
    chk("seq_word", {32'h0, po_d}, 64'h00A5_3000);

    // Atomic mode: loads stay invisible until latch, then all ports move together.
    drive(3'd0, OP_LD, 8'h11);
    tick();
    drive(3'd3, OP_LD, 8'h33);
    tick();
    wr_en = 1'b0;
    tick();
    chk("atm_count", {61'h0, cnt_a}, 64'h0);
    chk("atm_prelatch", {32'h0, po_a}, 64'h0);
    chk("dir_direct", {32'h0, po_d}, 64'h33A5_3011);
    latch = 1'b1;
    tick();
    latch = 1'b0;
    chk("atm_latch", {32'h0, po_a}, 64'h33A5_3011);
    chk("dir_latch_ign", {32'h0, po_d}, 64'h33A5_3011);
    // A latch on the same edge as a pop captures the pre-pop shadow.
    drive(3'd3, OP_LD, 8'h77);
    tick();
    wr_en = 1'b0;
    latch = 1'b1;
    tick();
    chk("atm_latch_pop", {32'h0, po_a}, 64'h33A5_3011);
    chk("dir_pop", {32'h0, po_d}, 64'h77A5_3011);
    tick();
    latch = 1'b0;
    chk("atm_next_latch", {32'h0, po_a}, 64'h77A5_3011);

    // Hold: fill the queue, drop one write, and check that set beats clr_err.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(3'(i), OP_LD, hold_dat[i]);
      tick();
    end
    chk("full_count", {61'h0, cnt_d}, 64'h4);
    chk("full_ready", {63'h0, rdy_d}, 64'h0);
    chk("full_ovf_pre", {63'h0, ovf_d}, 64'h0);
    drive(3'd0, OP_LD, 8'hFF);
    tick();
    chk("drop_ovf", {63'h0, ovf_d}, 64'h1);
    chk("drop_count", {61'h0, cnt_d}, 64'h4);
    chk("hold_port", {32'h0, po_d}, 64'h77A5_3011);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("set_wins", {63'h0, ovf_d}, 64'h1);
    // Release hold while a write is still presented: the pop happens and the push is rejected.
    hold = 1'b0;
    tick();
    wr_en = 1'b0;
    chk("drain0", {32'h0, po_d}, {32'h0, drain_exp[0]});
    chk("drain_count", {61'h0, cnt_d}, 64'h3);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain", {32'h0, po_d}, {32'h0, drain_exp[i]});
    end
    chk("drain_empty", {61'h0, cnt_d}, 64'h0);
    chk("ovf_sticky", {63'h0, ovf_d}, 64'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", {63'h0, ovf_d}, 64'h0);

    // An out-of-range sel is consumed without changing any port.
    chk("sel_pre", {24'h0, po_s}, 64'h00_0403_0201);
    drive(3'd5, OP_LD, 8'hEE);
    tick();
    wr_en = 1'b0;
    chk("sel_count1", {61'h0, cnt_s}, 64'h1);
    tick();
    chk("sel_count0", {61'h0, cnt_s}, 64'h0);
    chk("sel_port", {24'h0, po_s}, 64'h00_0403_0201);

    // Reset mid-operation with three entries queued.
    hold = 1'b1;
    drive(3'd0, OP_LD, 8'hAA);
    tick();
    drive(3'd1, OP_LD, 8'hBB);
    tick();
    drive(3'd2, OP_LD, 8'hCC);
    tick();
    wr_en = 1'b0;
    chk("q3_count", {61'h0, cnt_d}, 64'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_port", {32'h0, po_d}, 64'h0);
    chk("mid_rst_atm", {32'h0, po_a}, 64'h0);
    chk("mid_rst_count", {61'h0, cnt_d}, 64'h0);
    chk("mid_rst_ready", {63'h0, rdy_d}, 64'h1);
    hold = 1'b0;
    tick();
    // Release between edges and push on the very first edge afterwards.
    rst_n = 1'b1;
    drive(3'd3, OP_LD, 8'h5A);
    tick();
    wr_en = 1'b0;
    chk("post_rst_count", {61'h0, cnt_d}, 64'h1);
    chk("post_rst_port0", {32'h0, po_d}, 64'h0);
    tick();
    chk("post_rst_port", {32'h0, po_d}, 64'h5A00_0000);
    chk("post_rst_empty", {61'h0, cnt_d}, 64'h0);
    tick();
    chk("post_rst_stable", {32'h0, po_d}, 64'h5A00_0000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
